// File: rtl/reaction_fsm_pkg.sv
// Shared state codes and constants for the reaction timer; the LED display
// block imports the same state_e so both sides agree on the encoding.
package reaction_fsm_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        PREP        = 3'd1,
        TEST        = 3'd2,
        RESULT_OK   = 3'd3,
        RESULT_FAIL = 3'd4
    } state_e;

    localparam logic [13:0] BEST_RESET = 14'd9999;
    localparam logic [15:0] LFSR_SEED  = 16'hACE1;
    // Right-shift Galois taps for x^16+x^14+x^13+x^11+1
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;

    // Bits needed to hold values 0..max_val (at least one bit)
    function automatic int bits_for(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/reaction_fsm_if.sv
// Button inputs and result outputs of the reaction timer; the master side
// drives buttons and observes results.
interface reaction_fsm_if;
    import reaction_fsm_pkg::*;

    logic        btn_start;
    logic        btn_react;
    state_e      current_state;
    logic [13:0] reaction_ms;
    logic [13:0] best_ms;
    logic        is_high_score;

    modport master (output btn_start, btn_react,
                    input  current_state, reaction_ms, best_ms, is_high_score);
    modport slave  (input  btn_start, btn_react,
                    output current_state, reaction_ms, best_ms, is_high_score);
endinterface

// File: rtl/reaction_fsm_lfsr16.sv
// Free-running 16-bit Galois LFSR; the nonzero seed keeps it off the all-zero
// lock-up state.
module lfsr16
    import reaction_fsm_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] out
);
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    end

    always_ff @(posedge clk) begin
        if (reset) lfsr_q <= LFSR_SEED;
        else       lfsr_q <= lfsr_d;
    end

    assign out = lfsr_q;
endmodule

// File: rtl/reaction_fsm.sv
// Reaction-time game: random PREP delay, then time the player's press in TEST
// with a 1 ms prescaler, tracking the best valid result since reset.
module reaction_fsm
    import reaction_fsm_pkg::*;
#(
    parameter int TICKS_PER_MS = 100000,
    parameter int MIN_DELAY_MS = 1000,
    parameter int RAND_BITS    = 11,
    parameter int TIMEOUT_MS   = 9999
) (
    input  logic          clk,
    input  logic          reset,
    reaction_fsm_if.slave bus
);
    localparam int TICK_W = bits_for(TICKS_PER_MS - 1);
    localparam int DLY_W  = bits_for(MIN_DELAY_MS + (1 << RAND_BITS) - 1);
    localparam int MS_W   = bits_for(TIMEOUT_MS);
    localparam logic [15:0] RAND_MASK = 16'((1 << RAND_BITS) - 1);

    logic [15:0] lfsr_out;

    lfsr16 u_lfsr (.clk(clk), .reset(reset), .out(lfsr_out));

    state_e            state_q, state_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [DLY_W-1:0]  delay_q, delay_d;
    logic [MS_W-1:0]   ms_q, ms_d;
    logic [13:0]       reaction_q, reaction_d;
    logic [13:0]       best_q, best_d;
    logic              best_valid_q, best_valid_d;
    logic              hs_q, hs_d;

    logic              tick, timeout;
    logic [13:0]       react_val;
    logic [DLY_W-1:0]  delay_load;

    assign tick       = (tick_cnt_q == TICK_W'(TICKS_PER_MS - 1));
    assign timeout    = tick && (ms_q == MS_W'(TIMEOUT_MS - 1));
    assign delay_load = DLY_W'(MIN_DELAY_MS) + DLY_W'(lfsr_out & RAND_MASK);

    always_comb begin
        state_d      = state_q;
        delay_d      = delay_q;
        ms_d         = ms_q;
        reaction_d   = reaction_q;
        best_d       = best_q;
        best_valid_d = best_valid_q;
        hs_d         = hs_q;
        react_val    = timeout ? 14'(TIMEOUT_MS) : 14'(ms_q);

        case (state_q)
            IDLE: begin
                if (bus.btn_start) begin
                    state_d = PREP;
                    delay_d = delay_load;
                end
            end
            PREP: begin
                // A false start wins even if the delay expires on the same edge
                if (bus.btn_react) begin
                    state_d    = RESULT_FAIL;
                    reaction_d = '0;
                end else if (tick) begin
                    if (delay_q <= DLY_W'(1)) begin
                        state_d = TEST;
                        ms_d    = '0;
                    end else begin
                        delay_d = delay_q - DLY_W'(1);
                    end
                end
            end
            TEST: begin
                if (bus.btn_react) begin
                    state_d    = RESULT_OK;
                    reaction_d = react_val;
                    if (!best_valid_q || react_val < best_q) begin
                        best_d       = react_val;
                        best_valid_d = 1'b1;
                        hs_d         = 1'b1;
                    end
                end else if (timeout) begin
                    state_d    = RESULT_FAIL;
                    reaction_d = 14'(TIMEOUT_MS);
                end else if (tick) begin
                    ms_d = ms_q + MS_W'(1);
                end
            end
            RESULT_OK, RESULT_FAIL: begin
                if (bus.btn_start) begin
                    state_d = PREP;
                    delay_d = delay_load;
                    hs_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Prescaler restarts on any state change so the first tick is a full ms away
        tick_cnt_d = (state_d != state_q || tick) ? '0 : tick_cnt_q + TICK_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            tick_cnt_q   <= '0;
            delay_q      <= '0;
            ms_q         <= '0;
            reaction_q   <= '0;
            best_q       <= BEST_RESET;
            best_valid_q <= 1'b0;
            hs_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            delay_q      <= delay_d;
            ms_q         <= ms_d;
            reaction_q   <= reaction_d;
            best_q       <= best_d;
            best_valid_q <= best_valid_d;
            hs_q         <= hs_d;
        end
    end

    assign bus.current_state = state_q;
    assign bus.reaction_ms   = reaction_q;
    assign bus.best_ms       = best_q;
    assign bus.is_high_score = hs_q;
endmodule

// File: tb/tb_reaction_fsm.sv
// Directed bench for reaction_fsm with a small ms scale; a reference LFSR
// predicts each PREP length.
module tb_reaction_fsm;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    reaction_fsm_if bif ();

    reaction_fsm #(
        .TICKS_PER_MS(10), .MIN_DELAY_MS(2), .RAND_BITS(2), .TIMEOUT_MS(50)
    ) dut (.clk(clk), .reset(reset), .bus(bif));

    always #5 clk = ~clk;

    // Reference LFSR: x^16+x^14+x^13+x^11+1, Galois right-shift form
    logic [15:0] ref_lfsr;
    always @(posedge clk) begin
        if (reset) ref_lfsr <= 16'hACE1;
        else begin
            ref_lfsr <= ref_lfsr >> 1;
            if (ref_lfsr[0]) ref_lfsr <= (ref_lfsr >> 1) ^ 16'b1011_0100_0000_0000;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int st();
        return int'(bif.current_state);
    endfunction

    task automatic wait_state(input int target, input int budget, input string tag,
                              output int cyc);
        cyc = 0;
        while (st() != target && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        chk(tag, st(), target);
    endtask

    // Pulse btn_start; returns the PREP length the reference LFSR predicts
    task automatic do_start(output int exp_len);
        exp_len = (2 + int'(ref_lfsr[1:0])) * 10;
        bif.btn_start = 1'b1;
        @(negedge clk);
        bif.btn_start = 1'b0;
        chk("enter_prep", st(), 1);
    endtask

    task automatic start_to_test();
        int exp_len, cyc;
        do_start(exp_len);
        wait_state(2, 100, "reach_test", cyc);
        chk("prep_len", cyc, exp_len);
    endtask

    // Called at the first negedge in TEST: react is sampled k edges after entry
    task automatic react_at(input int k);
        repeat (k - 1) @(negedge clk);
        bif.btn_react = 1'b1;
        @(negedge clk);
        bif.btn_react = 1'b0;
    endtask

    initial begin
        int cyc, exp_len;
        bif.btn_start = 1'b0;
        bif.btn_react = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_state", st(), 0);
        chk("rst_reaction", int'(bif.reaction_ms), 0);
        chk("rst_best", int'(bif.best_ms), 9999);
        chk("rst_hs", int'(bif.is_high_score), 0);
        reset = 1'b0;
        @(negedge clk);

        // react in IDLE is ignored
        bif.btn_react = 1'b1;
        @(negedge clk);
        bif.btn_react = 1'b0;
        chk("idle_react", st(), 0);

        // Round 1: 5 ms
        start_to_test();
        react_at(55);
        chk("r1_state", st(), 3);
        chk("r1_reaction", int'(bif.reaction_ms), 5);
        chk("r1_best", int'(bif.best_ms), 5);
        chk("r1_hs", int'(bif.is_high_score), 1);

        // Round 2: 7 ms, not a best
        start_to_test();
        chk("r2_hs_cleared", int'(bif.is_high_score), 0);
        react_at(75);
        chk("r2_reaction", int'(bif.reaction_ms), 7);
        chk("r2_best", int'(bif.best_ms), 5);
        chk("r2_hs", int'(bif.is_high_score), 0);

        // Round 3: tie at 5 ms
        start_to_test();
        react_at(55);
        chk("r3_state", st(), 3);
        chk("r3_reaction", int'(bif.reaction_ms), 5);
        chk("r3_hs_tie", int'(bif.is_high_score), 0);

        // False start one cycle into PREP
        do_start(exp_len);
        bif.btn_react = 1'b1;
        @(negedge clk);
        bif.btn_react = 1'b0;
        chk("fs_state", st(), 4);
        chk("fs_reaction", int'(bif.reaction_ms), 0);
        chk("fs_best", int'(bif.best_ms), 5);

        // btn_start ignored in PREP and TEST, then reset mid-TEST
        do_start(exp_len);
        bif.btn_start = 1'b1;
        @(negedge clk);
        bif.btn_start = 1'b0;
        chk("prep_ign_start", st(), 1);
        wait_state(2, 100, "reach_test2", cyc);
        chk("prep_len_ign", cyc + 1, exp_len);
        bif.btn_start = 1'b1;
        @(negedge clk);
        bif.btn_start = 1'b0;
        chk("test_ign_start", st(), 2);
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_state", st(), 0);
        chk("midrst_best", int'(bif.best_ms), 9999);
        chk("midrst_hs", int'(bif.is_high_score), 0);
        chk("midrst_reaction", int'(bif.reaction_ms), 0);
        reset = 1'b0;
        @(negedge clk);

        // Timeout with no react
        start_to_test();
        wait_state(4, 600, "to_reach_fail", cyc);
        chk("to_cycles", cyc, 500);
        chk("to_reaction", int'(bif.reaction_ms), 50);

        // React on the timeout edge wins; first valid best after reset
        start_to_test();
        react_at(500);
        chk("to_react_state", st(), 3);
        chk("to_react_reaction", int'(bif.reaction_ms), 50);
        chk("to_react_best", int'(bif.best_ms), 50);
        chk("to_react_hs", int'(bif.is_high_score), 1);

        // PREP length against the reference LFSR over 20 rounds
        for (int r = 0; r < 20; r++) begin
            start_to_test();
            react_at(1);
        end
        chk("loop_reaction", int'(bif.reaction_ms), 0);
        chk("loop_best", int'(bif.best_ms), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/reaction_fsm.md
REACTION_FSM -- requirements
Module: reaction_fsm

Interface
REQ-001 Parameter TICKS_PER_MS, default 100000, clk cycles per millisecond tick.
REQ-002 Parameter MIN_DELAY_MS, default 1000, fixed part of PREP delay in ms.
REQ-003 Parameter RAND_BITS, default 11, LFSR bits added to the PREP delay, giving 0..2^RAND_BITS-1 ms.
REQ-004 Parameter TIMEOUT_MS, default 9999, TEST-state give-up limit in ms.
REQ-005 clk  input  1  sole clock; all state changes occur on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 btn_start  input  1  debounced single-cycle start pulse.
REQ-008 btn_react  input  1  debounced single-cycle reaction pulse.
REQ-009 current_state  output  3  registered state code from the shared state defines.
REQ-010 reaction_ms  output  14  registered result of the last round in ms.
REQ-011 best_ms  output  14  registered best (lowest) valid reaction since reset.
REQ-012 is_high_score  output  1  registered; high in RESULT_OK when this round set a new best.

Function
REQ-013 States SHALL be IDLE, PREP, TEST, RESULT_OK, RESULT_FAIL; every transition SHALL take effect on the clock edge that samples its cause, so the output changes 1 cycle later.
REQ-014 IDLE: btn_start -> PREP, loading delay_ms = MIN_DELAY_MS + lfsr[RAND_BITS-1:0], sampled on that same edge; btn_react ignored.
REQ-015 PREP: a 1 ms tick counter counts down delay_ms; on expiry -> TEST with ms_count cleared to 0.
REQ-016 PREP: btn_react -> RESULT_FAIL (false start), reaction_ms := 0; if btn_react and expiry coincide, RESULT_FAIL wins.
REQ-017 TEST: ms_count increments once per TICKS_PER_MS cycles; btn_react -> RESULT_OK, reaction_ms := ms_count as of that edge.
REQ-018 TEST: ms_count reaching TIMEOUT_MS -> RESULT_FAIL, reaction_ms := TIMEOUT_MS; if btn_react arrives on that same edge, RESULT_OK wins with reaction_ms = TIMEOUT_MS.
REQ-019 Entering RESULT_OK with reaction_ms strictly less than best_ms, or with no valid best yet: best_ms updates and is_high_score := 1 on the same edge; a tie is not a high score.
REQ-020 RESULT_OK / RESULT_FAIL: btn_start -> PREP (new round, new random delay); is_high_score := 0 on leaving; btn_react ignored.
REQ-021 btn_start SHALL be ignored in PREP and TEST.
REQ-022 Tick prescaler SHALL restart from 0 on every state entry, so the first ms tick is a full TICKS_PER_MS cycles away.
REQ-023 LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1, advances every cycle, never reaches all-zero.
REQ-024 Simultaneous btn_start and btn_react: each state honours only the button it listens to.

Reset
REQ-025 reset SHALL force: current_state = IDLE, reaction_ms = 0, best_ms = 9999 with the valid-best flag cleared, is_high_score = 0, all counters 0, LFSR = 16'hACE1.
REQ-026 reset SHALL take priority over every other input in any state, including mid-PREP and mid-TEST.

Structure
REQ-027 State codes SHALL live in the shared state defines file (IDLE=0, PREP=1, TEST=2, RESULT_OK=3, RESULT_FAIL=4), which the LED display block also uses.
REQ-028 The LFSR SHALL be a separate sub-module, lfsr16 (ports clk, reset, out[15:0]).
REQ-029 Counters SHALL be sized from the parameters, with no truncation at the default values.

Verification (TICKS_PER_MS=10, MIN_DELAY_MS=2, RAND_BITS=2, TIMEOUT_MS=50)
REQ-030 reset, btn_start, btn_react 5 ms after TEST entry -> RESULT_OK, reaction_ms=5, best_ms=5, is_high_score=1.
REQ-031 Second round with react at 7 ms -> reaction_ms=7, best_ms=5, is_high_score=0; third round at 5 ms -> is_high_score=0 (tie).
REQ-032 btn_react 1 cycle after entering PREP -> RESULT_FAIL, reaction_ms=0, best_ms unchanged.
REQ-033 No react in TEST -> RESULT_FAIL after exactly 500 cycles, reaction_ms=50; react on the timeout edge -> RESULT_OK, reaction_ms=50.
REQ-034 reset asserted mid-TEST -> next cycle IDLE, best_ms=9999, is_high_score=0; btn_start in PREP/TEST -> no state change.
REQ-035 PREP duration SHALL equal (2 + lfsr[1:0] at start) x 10 cycles, checked against a reference LFSR model over 20 rounds.
